gcd_requester: RTL and testbench



---
 rtl/gcd_pkg.sv | 24 ++
 rtl/gcd_req_watchdog.sv | 32 +++
 rtl/gcd_requester.sv | 144 ++++++++++++++
 tb/tb_gcd_requester.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared width, tag and timeout defaults plus the requester FSM state type.
package gcd_pkg;

    localparam int GCD_W       = 32;
    localparam int GCD_TAG_W   = 4;
    localparam int GCD_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2,
        OUTPUT  = 2'd3
    } gcd_state_t;

    // gcd(0,x) = x and gcd(0,0) = 0, so OR-ing the operands gives the answer
    // whenever at least one of them is zero.
    function automatic logic [GCD_W-1:0] gcd_bypass_value(
        input logic [GCD_W-1:0] a,
        input logic [GCD_W-1:0] b
    );
        return a | b;
    endfunction

endpackage

// File: rtl/gcd_req_watchdog.sv
// gcd_req_watchdog: cycle counter that flags a gcd request stuck in ISSUE.
// Only built when GCD_REQ_TIMEOUT_EN is defined.
`ifdef GCD_REQ_TIMEOUT_EN
module gcd_req_watchdog
    import gcd_pkg::*;
#(
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] count;

    // Count cycles while run is high, restarting from zero whenever run drops
    // and holding once the limit is reached.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = run && (count == CNT_W'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/gcd_requester.sv
// gcd_requester: turns a valid/ready operand stream into start/done transactions
// on one gcd core and returns each result with its tag on a valid/ready stream.
// Optional feature macro: GCD_REQ_TIMEOUT_EN (abort a request after TIMEOUT
// cycles in ISSUE without done, reporting out_err=1 and out_result=0).
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int W       = GCD_W,
    parameter int TAG_W   = GCD_TAG_W,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_opa,
    input  logic [W-1:0]     in_opb,
    input  logic [TAG_W-1:0] in_tag,
    output logic [W-1:0]     gcd_opa,
    output logic [W-1:0]     gcd_opb,
    output logic             gcd_start,
    input  logic [W-1:0]     gcd_result,
    input  logic             gcd_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);

    if (W != GCD_W || TAG_W < 1 || TIMEOUT < 2) begin : g_bad_params
        $error("gcd_requester: W must equal GCD_W, TAG_W >= 1, TIMEOUT >= 2");
    end

    gcd_state_t state;
    logic       first_issue;
    logic       accept;
    logic       timed_out;

`ifdef GCD_REQ_TIMEOUT_EN
    logic issuing;
    logic err_q;

    assign issuing = (state == ISSUE);

    gcd_req_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .run     (issuing),
        .expired (timed_out)
    );

    assign out_err = err_q;
`else
    assign timed_out = 1'b0;
    assign out_err   = 1'b0;
`endif

    // Ready only in IDLE and never while reset is held, so nothing is accepted
    // in the reset cycle and the first cycle after reset is already ready.
    assign in_ready = (state == IDLE) && !reset;
    assign accept   = in_valid && in_ready;

    // Requester FSM: accept a pair, run it through the core (or bypass it when
    // an operand is zero), then hold the result until the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            first_issue <= 1'b0;
            gcd_start   <= 1'b0;
            gcd_opa     <= '0;
            gcd_opb     <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_tag     <= '0;
            busy        <= 1'b0;
`ifdef GCD_REQ_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_tag <= in_tag;
                        busy    <= 1'b1;
                        if (in_opa != '0 && in_opb != '0) begin
                            gcd_opa     <= in_opa;
                            gcd_opb     <= in_opb;
                            gcd_start   <= 1'b1;
                            first_issue <= 1'b1;
                            state       <= ISSUE;
                        end else begin
                            out_result <= gcd_bypass_value(in_opa, in_opb);
                            out_valid  <= 1'b1;
                            state      <= OUTPUT;
                        end
                    end
                end

                ISSUE: begin
                    first_issue <= 1'b0;
                    if (!first_issue && gcd_done) begin
                        out_result <= gcd_result;
                        gcd_start  <= 1'b0;
                        state      <= RELEASE;
                    end else if (timed_out) begin
                        out_result <= '0;
                        gcd_start  <= 1'b0;
                        state      <= RELEASE;
`ifdef GCD_REQ_TIMEOUT_EN
                        err_q      <= 1'b1;
`endif
                    end
                end

                RELEASE: begin
                    if (!gcd_done) begin
                        out_valid <= 1'b1;
                        state     <= OUTPUT;
                    end
                end

                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
`ifdef GCD_REQ_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_requester.sv
// tb_gcd_requester: bench for gcd_requester with a behavioural gcd core.
// Timeout sequence is built only when GCD_REQ_TIMEOUT_EN is defined.
module tb_gcd_requester;
    import gcd_pkg::*;

`ifdef GCD_REQ_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 1024;
`endif

    typedef struct {
        logic [31:0] opa;
        logic [31:0] opb;
        logic [3:0]  tag;
        logic [31:0] expResult;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_opa = '0;
    logic [31:0] in_opb = '0;
    logic [3:0]  in_tag = '0;
    logic [31:0] gcd_opa;
    logic [31:0] gcd_opb;
    logic        gcd_start;
    logic [31:0] gcd_result;
    logic        gcd_done;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic        out_err;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    exp_t expQ[$];

    int          coreLat = 3;
    bit          coreNever = 1'b0;
    logic        coreDone = 1'b0;
    logic [31:0] coreRes = '0;
    int          coreCnt = 0;
    bit          override = 1'b0;
    logic        ovrDone = 1'b0;
    logic [31:0] ovrResult = '0;

    gcd_requester #(
        .W       (32),
        .TAG_W   (4),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opa     (in_opa),
        .in_opb     (in_opb),
        .in_tag     (in_tag),
        .gcd_opa    (gcd_opa),
        .gcd_opb    (gcd_opb),
        .gcd_start  (gcd_start),
        .gcd_result (gcd_result),
        .gcd_done   (gcd_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] refGcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x = a;
        logic [31:0] y = b;
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Behavioural core: done rises coreLat cycles after start is seen and is held until start falls.
    always @(posedge clk) begin
        if (reset || !gcd_start) begin
            coreDone <= 1'b0;
            coreCnt  <= 0;
        end else if (!coreDone && !coreNever) begin
            if (coreCnt >= coreLat) begin
                coreDone <= 1'b1;
                coreRes  <= refGcd(gcd_opa, gcd_opb);
            end else begin
                coreCnt <= coreCnt + 1;
            end
        end
    end

    assign gcd_done   = override ? ovrDone   : coreDone;
    assign gcd_result = override ? ovrResult : coreRes;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] t, input logic [31:0] er);
        exp_t e;
        int n = 0;
        in_opa   = a;
        in_opb   = b;
        in_tag   = t;
        in_valid = 1'b1;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0 for %0d cycles, wanted 1", n);
            in_valid = 1'b0;
            return;
        end
        e.result = er;
        e.tag    = t;
        expQ.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input int count, input logic [3:0] pat);
        int got = 0;
        int cyc = 0;
        bit held = 1'b0;
        logic [31:0] hr = '0;
        logic [3:0]  ht = '0;
        while (got < count && cyc < 5000) begin
            out_ready = pat[cyc % 4];
            if (out_valid) begin
                if (held) begin
                    check("stall_result", out_result, hr);
                    check("stall_tag", out_tag, ht);
                end
                if (out_ready) begin
                    if (expQ.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_output: got result 0x%0h, wanted no output", out_result);
                    end else begin
                        exp_t e = expQ.pop_front();
                        check("result", out_result, e.result);
                        check("tag", out_tag, e.tag);
                        check("err", out_err, 1'b0);
                    end
                    got++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hr   = out_result;
                    ht   = out_tag;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        if (got < count) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL output_timeout: got %0d results, wanted %0d", got, count);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish, wanted completion");
        $fatal(1, "[TB] hang");
    end

    initial begin
        vec_t tbl[8];
        tbl[0] = '{32'd0,          32'd36,         4'd1,  32'd36};
        tbl[1] = '{32'd0,          32'd0,          4'd2,  32'd0};
        tbl[2] = '{32'd36,         32'd0,          4'd7,  32'd36};
        tbl[3] = '{32'd48,         32'd18,         4'd10, 32'd6};
        tbl[4] = '{32'd17,         32'd5,          4'd11, 32'd1};
        tbl[5] = '{32'd1024,       32'd4096,       4'd12, 32'd1024};
        tbl[6] = '{32'hFFFF_FFFF,  32'h0000_FFFF,  4'd13, 32'h0000_FFFF};
        tbl[7] = '{32'd1,          32'd1,          4'd14, 32'd1};

        // Reset values while reset is held, then ready in the first cycle after.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_start", gcd_start, 1'b0);
        check("rst_opa", gcd_opa, 32'd0);
        check("rst_opb", gcd_opb, 32'd0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_tag", out_tag, 4'd0);
        check("rst_out_err", out_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);

        // (1075,255): start held until done, in_ready low throughout.
        coreLat = 3;
        applyStimulus(32'd1075, 32'd255, 4'd3, 32'd5);
        check("t1_busy", busy, 1'b1);
        begin
            int n = 0;
            bit rdySeen = 1'b0;
            bit earlyDrop = 1'b0;
            bit doneSeen = 1'b0;
            int startCycles = 0;
            while (!out_valid && n < 200) begin
                if (in_ready) rdySeen = 1'b1;
                if (gcd_start) startCycles++;
                if (!doneSeen && !gcd_start) earlyDrop = 1'b1;
                if (gcd_done) doneSeen = 1'b1;
                @(negedge clk);
                n++;
            end
            check("t1_in_ready_low", rdySeen, 1'b0);
            check("t1_start_held", earlyDrop, 1'b0);
            check("t1_start_seen", startCycles > 0, 1'b1);
        end
        checkOutput(1, 4'b1111);

        // Table of pairs, zero operands bypass the core with 1-cycle latency.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].opa, tbl[i].opb, tbl[i].tag, tbl[i].expResult);
            if (tbl[i].opa == 0 || tbl[i].opb == 0) begin
                check("bypass_latency", out_valid, 1'b1);
                check("bypass_no_start", gcd_start, 1'b0);
            end
            checkOutput(1, 4'b1111);
        end

        // Back-to-back pairs against a 1-0-0-1 out_ready pattern.
        fork
            begin
                applyStimulus(32'd48, 32'd18, 4'd4, 32'd6);
                applyStimulus(32'd17, 32'd5, 4'd5, 32'd1);
                applyStimulus(32'd1024, 32'd4096, 4'd6, 32'd1024);
            end
            checkOutput(3, 4'b1001);
        join

        // Reset three cycles into ISSUE discards the request.
        coreLat = 20;
        applyStimulus(32'd1075, 32'd255, 4'd3, 32'd5);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        expQ.delete();
        #1;
        check("midrst_start", gcd_start, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        @(negedge clk);
        coreLat = 3;
        applyStimulus(32'd21, 32'd14, 4'd9, 32'd7);
        checkOutput(1, 4'b1111);

        // Stale done carried into the first ISSUE cycle must be ignored.
        override  = 1'b1;
        ovrResult = 32'h0000_0BAD;
        ovrDone   = 1'b1;
        @(negedge clk);
        check("idle_done_no_valid", out_valid, 1'b0);
        check("idle_done_ready", in_ready, 1'b1);
        applyStimulus(32'd21, 32'd14, 4'd8, 32'd7);
        @(negedge clk);
        ovrDone = 1'b0;
        repeat (2) @(negedge clk);
        ovrResult = 32'd7;
        ovrDone   = 1'b1;
        begin
            int n = 0;
            while (gcd_start && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        ovrDone = 1'b0;
        checkOutput(1, 4'b1111);
        override = 1'b0;

`ifdef GCD_REQ_TIMEOUT_EN
        // Core never answers: abort after TIMEOUT ISSUE cycles.
        coreNever = 1'b1;
        applyStimulus(32'd9, 32'd6, 4'd4, 32'd0);
        expQ.delete();
        begin
            int n = 0;
            int sc = 0;
            while (!out_valid && n < 200) begin
                if (gcd_start) sc++;
                @(negedge clk);
                n++;
            end
            check("to_issue_cycles", sc, 64'd16);
            check("to_out_valid", out_valid, 1'b1);
            check("to_out_err", out_err, 1'b1);
            check("to_out_result", out_result, 32'd0);
            check("to_start", gcd_start, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("to_err_cleared", out_err, 1'b0);
        check("to_valid_cleared", out_valid, 1'b0);
        coreNever = 1'b0;
`endif

        // Randomized pairs with random core latency and back-pressure.
        coreLat = $urandom_range(0, 4);
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [31:0] k;
                    logic [31:0] a;
                    logic [31:0] b;
                    k = $urandom_range(1, 50);
                    a = ($urandom_range(0, 7) == 0) ? 32'd0 : k * $urandom_range(1, 2000);
                    b = ($urandom_range(0, 7) == 0) ? 32'd0 : k * $urandom_range(1, 2000);
                    applyStimulus(a, b, 4'($urandom_range(0, 15)), refGcd(a, b));
                end
            end
            checkOutput(24, 4'($urandom_range(1, 15)));
        join

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
